// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axi_lite_cmd_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WRESP,
    ST_READ,
    ST_RDATA,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_stat_counter.sv
// Saturating 16-bit event counter; only built with AXI_LITE_CMD_MASTER_STATS_EN.
`ifdef AXI_LITE_CMD_MASTER_STATS_EN
module axi_lite_stat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'h0001;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/axi_lite_cmd_master.sv
// Converts a single-beat cmd/rsp interface into one AXI4-Lite transaction at a time.
// Optional statistics outputs are enabled with AXI_LITE_CMD_MASTER_STATS_EN.
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
`ifdef AXI_LITE_CMD_MASTER_STATS_EN
  ,
  output logic [15:0]                     stat_wr_count,
  output logic [15:0]                     stat_rd_count,
  output logic [15:0]                     stat_err_count
`endif
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef struct packed {
    logic          cmd_ready;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          awvalid;
    logic          wvalid;
    logic          bready;
    logic          arvalid;
    logic          rready;
    logic          rsp_valid;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } regs_t;

  state_e state_q, state_d;
  regs_t  regs_q, regs_d;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      regs_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every field and no latch is inferred.
    state_d = state_q;
    regs_d  = regs_q;
    case (state_q)
      ST_IDLE: begin
        regs_d.cmd_ready = 1'b1;
        if (cmd_valid && regs_q.cmd_ready) begin
          regs_d.cmd_ready = 1'b0;
          regs_d.write     = cmd_write;
          regs_d.addr      = cmd_addr;
          regs_d.wdata     = cmd_wdata;
          regs_d.wstrb     = cmd_wstrb;
          if (cmd_write) begin
            state_d        = ST_WRITE;
            regs_d.awvalid = 1'b1;
            regs_d.wvalid  = 1'b1;
          end else begin
            state_d        = ST_READ;
            regs_d.arvalid = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (regs_q.awvalid && M_AXI_AWREADY) regs_d.awvalid = 1'b0;
        if (regs_q.wvalid && M_AXI_WREADY)   regs_d.wvalid  = 1'b0;
        // A dropped VALID is the record that its channel has handshaken.
        if (!regs_q.awvalid && !regs_q.wvalid) begin
          state_d       = ST_WRESP;
          regs_d.bready = 1'b1;
        end
      end
      ST_WRESP: begin
        if (M_AXI_BVALID) begin
          state_d          = ST_RESP;
          regs_d.bready    = 1'b0;
          regs_d.resp      = M_AXI_BRESP;
          regs_d.rdata     = '0;
          regs_d.rsp_valid = 1'b1;
        end
      end
      ST_READ: begin
        if (M_AXI_ARREADY) begin
          state_d        = ST_RDATA;
          regs_d.arvalid = 1'b0;
          regs_d.rready  = 1'b1;
        end
      end
      ST_RDATA: begin
        if (M_AXI_RVALID) begin
          state_d          = ST_RESP;
          regs_d.rready    = 1'b0;
          regs_d.resp      = M_AXI_RRESP;
          regs_d.rdata     = M_AXI_RDATA;
          regs_d.rsp_valid = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d          = ST_IDLE;
          regs_d.rsp_valid = 1'b0;
          regs_d.cmd_ready = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready     = regs_q.cmd_ready;
  assign rsp_valid     = regs_q.rsp_valid;
  assign rsp_rdata     = regs_q.rdata;
  assign rsp_resp      = regs_q.resp;
  assign M_AXI_AWADDR  = regs_q.addr;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = regs_q.awvalid;
  assign M_AXI_WDATA   = regs_q.wdata;
  assign M_AXI_WSTRB   = regs_q.wstrb;
  assign M_AXI_WVALID  = regs_q.wvalid;
  assign M_AXI_BREADY  = regs_q.bready;
  assign M_AXI_ARADDR  = regs_q.addr;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = regs_q.arvalid;
  assign M_AXI_RREADY  = regs_q.rready;

`ifdef AXI_LITE_CMD_MASTER_STATS_EN
  logic rsp_done;
  assign rsp_done = regs_q.rsp_valid && rsp_ready;

  axi_lite_stat_counter u_wr_count (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .inc_i   (rsp_done && regs_q.write),
    .count_o (stat_wr_count)
  );

  axi_lite_stat_counter u_rd_count (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .inc_i   (rsp_done && !regs_q.write),
    .count_o (stat_rd_count)
  );

  axi_lite_stat_counter u_err_count (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .inc_i   (rsp_done && (regs_q.resp != RESP_OKAY)),
    .count_o (stat_err_count)
  );
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Scoreboarded bench: a memory-backed AXI4-Lite slave model with programmable delays
// and a response monitor that compares each handshake against a reference memory.
module tb_axi_lite_cmd_master;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [SW-1:0] M_AXI_WSTRB;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;
`ifdef AXI_LITE_CMD_MASTER_STATS_EN
  logic [15:0]   stat_wr_count, stat_rd_count, stat_err_count;
`endif

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
`ifdef AXI_LITE_CMD_MASTER_STATS_EN
    , .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count), .stat_err_count(stat_err_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          wr;
    int            lat;   // expected cycles from acceptance to rsp_valid, -1 = unchecked
  } exp_t;

  exp_t          exp_q[$];
  logic [1:0]    slv_resp_q[$];
  logic [DW-1:0] model_mem[4];
  logic [DW-1:0] slv_mem[4];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
  logic          rsp_rand = 1'b0;
  logic          rsp_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < SW; i++) if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // ---------------- slave model: decides READYs/responses at negedge ----------------
  initial begin
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, b_pend, r_pend;
    logic p_awv, p_wv, p_arv;
    logic [AW-1:0] p_awaddr, p_araddr, cap_awaddr, cap_araddr;
    logic [DW-1:0] p_wdata, cap_wdata;
    logic [SW-1:0] p_wstrb, cap_wstrb;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, b_pend, r_pend, p_awv, p_wv, p_arv} = '0;
    {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
    {p_awaddr, p_araddr, cap_awaddr, cap_araddr, p_wdata, cap_wdata, p_wstrb, cap_wstrb} = '0;
    {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY, M_AXI_BVALID, M_AXI_RVALID} = '0;
    M_AXI_BRESP = 2'b00; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_got, w_got, b_pend, r_pend, p_awv, p_wv, p_arv} = '0;
        {aw_cnt, w_cnt, ar_cnt} = '0;
        {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_ARREADY, M_AXI_BVALID, M_AXI_RVALID} = '0;
      end else begin
        // VALID held and payload stable until handshake, dropped right after it
        if (p_awv && !aw_hs) begin
          check("awvalid_hold", M_AXI_AWVALID, 1'b1);
          check("awaddr_stable", M_AXI_AWADDR, p_awaddr);
        end
        if (p_wv && !w_hs) begin
          check("wvalid_hold", M_AXI_WVALID, 1'b1);
          check("wdata_stable", {M_AXI_WSTRB, M_AXI_WDATA}, {p_wstrb, p_wdata});
        end
        if (p_arv && !ar_hs) begin
          check("arvalid_hold", M_AXI_ARVALID, 1'b1);
          check("araddr_stable", M_AXI_ARADDR, p_araddr);
        end
        if (aw_hs) check("awvalid_drop", M_AXI_AWVALID, 1'b0);
        if (w_hs)  check("wvalid_drop", M_AXI_WVALID, 1'b0);
        if (ar_hs) check("arvalid_drop", M_AXI_ARVALID, 1'b0);

        if (aw_hs) aw_got = 1'b1;
        if (w_hs)  w_got  = 1'b1;
        if (aw_got && w_got) begin
          slv_mem[cap_awaddr[3:2]] = merge(slv_mem[cap_awaddr[3:2]], cap_wdata, cap_wstrb);
          aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1; b_cnt = cfg_b_dly;
        end
        if (b_hs) M_AXI_BVALID = 1'b0;
        if (ar_hs) begin r_pend = 1'b1; r_cnt = cfg_r_dly; end
        if (r_hs) M_AXI_RVALID = 1'b0;

        if (b_pend) begin
          if (b_cnt == 0) begin
            M_AXI_BVALID = 1'b1; b_pend = 1'b0;
            if (slv_resp_q.size() == 0) check("slave_bresp_queue", 0, 1);
            else M_AXI_BRESP = slv_resp_q.pop_front();
          end else b_cnt--;
        end
        if (!M_AXI_RVALID) M_AXI_RDATA = $urandom;
        if (r_pend) begin
          if (r_cnt == 0) begin
            M_AXI_RVALID = 1'b1; r_pend = 1'b0;
            M_AXI_RDATA  = slv_mem[cap_araddr[3:2]];
            if (slv_resp_q.size() == 0) check("slave_rresp_queue", 0, 1);
            else M_AXI_RRESP = slv_resp_q.pop_front();
          end else r_cnt--;
        end

        if (M_AXI_AWVALID && !aw_got) begin
          if (aw_cnt >= cfg_aw_dly) M_AXI_AWREADY = 1'b1; else begin M_AXI_AWREADY = 1'b0; aw_cnt++; end
        end else begin M_AXI_AWREADY = 1'b0; aw_cnt = 0; end
        if (M_AXI_WVALID && !w_got) begin
          if (w_cnt >= cfg_w_dly) M_AXI_WREADY = 1'b1; else begin M_AXI_WREADY = 1'b0; w_cnt++; end
        end else begin M_AXI_WREADY = 1'b0; w_cnt = 0; end
        if (M_AXI_ARVALID) begin
          if (ar_cnt >= cfg_ar_dly) M_AXI_ARREADY = 1'b1; else begin M_AXI_ARREADY = 1'b0; ar_cnt++; end
        end else begin M_AXI_ARREADY = 1'b0; ar_cnt = 0; end

        aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
        w_hs  = M_AXI_WVALID && M_AXI_WREADY;
        ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
        b_hs  = M_AXI_BVALID && M_AXI_BREADY;
        r_hs  = M_AXI_RVALID && M_AXI_RREADY;
        if (aw_hs) begin cap_awaddr = M_AXI_AWADDR; check("awprot", M_AXI_AWPROT, 3'b000); end
        if (w_hs)  begin cap_wdata = M_AXI_WDATA; cap_wstrb = M_AXI_WSTRB; end
        if (ar_hs) begin cap_araddr = M_AXI_ARADDR; check("arprot", M_AXI_ARPROT, 3'b000); end
        p_awv = M_AXI_AWVALID; p_awaddr = M_AXI_AWADDR;
        p_wv  = M_AXI_WVALID;  p_wdata  = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
        p_arv = M_AXI_ARVALID; p_araddr = M_AXI_ARADDR;
      end
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  initial begin
    logic p_rv, p_rr, stat_pend;
    logic [DW-1:0] p_rdata;
    logic [1:0] p_resp;
    int acc_cyc, m_wr, m_rd, m_err;
    exp_t e;
    {p_rv, p_rr, stat_pend} = '0; p_rdata = '0; p_resp = '0;
    acc_cyc = 0; m_wr = 0; m_rd = 0; m_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {p_rv, p_rr, stat_pend} = '0; m_wr = 0; m_rd = 0; m_err = 0;
      end else begin
`ifdef AXI_LITE_CMD_MASTER_STATS_EN
        if (stat_pend) begin
          check("stat_wr_count", stat_wr_count, m_wr);
          check("stat_rd_count", stat_rd_count, m_rd);
          check("stat_err_count", stat_err_count, m_err);
        end
`endif
        stat_pend = 1'b0;
        if (p_rv && !p_rr) begin
          check("rsp_valid_hold", rsp_valid, 1'b1);
          check("rsp_stable", {rsp_resp, rsp_rdata}, {p_resp, p_rdata});
        end
        if (p_rv && p_rr) check("rsp_valid_drop", rsp_valid, 1'b0);
        if (rsp_valid) check("cmd_ready_busy", cmd_ready, 1'b0);
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (rsp_valid && !p_rv && exp_q.size() != 0 && exp_q[0].lat >= 0)
          check("latency", cyc - acc_cyc, exp_q[0].lat);
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", rsp_resp, e.resp);
            if (e.wr) m_wr = (m_wr < 65535) ? m_wr + 1 : m_wr;
            else      m_rd = (m_rd < 65535) ? m_rd + 1 : m_rd;
            if (e.resp != 2'b00) m_err = (m_err < 65535) ? m_err + 1 : m_err;
            stat_pend = 1'b1;
          end
        end
        p_rv = rsp_valid; p_rr = rsp_ready; p_rdata = rsp_rdata; p_resp = rsp_resp;
      end
    end
  end

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : rsp_force;
    end
  end

  // ---------------- stimulus ----------------
  task automatic prep(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input logic [1:0] resp, input int lat);
    exp_t e;
    if (wr) model_mem[addr[3:2]] = merge(model_mem[addr[3:2]], wdata, strb);
    e.rdata = wr ? '0 : model_mem[addr[3:2]];
    e.resp = resp; e.wr = wr; e.lat = lat;
    exp_q.push_back(e);
    slv_resp_q.push_back(resp);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 300) begin check("accept_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic transact(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input logic [1:0] resp, input int lat);
    prep(wr, addr, wdata, strb, resp, lat);
    wait_accept();
    wait_done();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_axi_valids"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 3'b000);
    check({tag, "_axi_readys"}, {M_AXI_BREADY, M_AXI_RREADY}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] d;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    for (int i = 0; i < 4; i++) begin d = $urandom; model_mem[i] = d; slv_mem[i] = d; end

    #1;
    check_quiet("reset");
    check("reset_rsp_data", {rsp_resp, rsp_rdata}, '0);
    check("reset_axi_payload", {M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB}, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);

    // directed: minimum latencies with ready slave
    transact(1'b1, 4'h4, 32'h0000_00A5, 4'hF, 2'b00, 4);
    transact(1'b0, 4'h4, '0, '0, 2'b00, 3);
    transact(1'b1, 4'h8, 32'h1234_5678, 4'hF, 2'b00, 4);
    cfg_r_dly = 1;
    transact(1'b0, 4'h8, '0, '0, 2'b00, -1);
    cfg_r_dly = 0;

    // W before AW, then AW before W, with partial strobes
    cfg_aw_dly = 3; cfg_w_dly = 0;
    transact(1'b1, 4'h0, 32'hDEAD_BEEF, 4'b0101, 2'b00, -1);
    cfg_aw_dly = 0; cfg_w_dly = 3;
    transact(1'b1, 4'h0, 32'hCAFE_F00D, 4'b1010, 2'b00, -1);
    cfg_w_dly = 0;
    transact(1'b0, 4'h0, '0, '0, 2'b00, 3);

    // error pass-through
    transact(1'b0, 4'hC, '0, '0, 2'b10, 3);
    transact(1'b1, 4'hC, 32'h0BAD_0BAD, 4'hF, 2'b11, 4);

    // back-pressure: response held while a second command waits
    rsp_force = 1'b0;
    prep(1'b0, 4'h4, '0, '0, 2'b01, -1);
    wait_accept();
    n = 0;
    while (1) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
      if (n > 100) begin check("hold_rsp_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    prep(1'b1, 4'h8, 32'h5555_AAAA, 4'hF, 2'b00, -1);
    repeat (5) begin
      @(negedge clk);
      check("hold_cmd_ready", cmd_ready, 1'b0);
      check("hold_rsp_valid", rsp_valid, 1'b1);
    end
    @(posedge clk); #1 rsp_force = 1'b1;
    wait_accept();
    wait_done();

    // reset while waiting in WRESP
    cfg_b_dly = 10;
    prep(1'b1, 4'h8, 32'h7777_0000, 4'hF, 2'b00, -1);
    wait_accept();
    n = 0;
    while (1) begin
      @(negedge clk);
      if (M_AXI_BREADY) break;
      n++;
      if (n > 100) begin check("wresp_wait_timeout", 0, 1); break; end
    end
    #2 rst_n = 1'b0;
    #1 check_quiet("midreset");
    exp_q.delete();
    slv_resp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cfg_b_dly = 0;
    @(posedge clk); #1;
    check("cmd_ready_after_midreset", cmd_ready, 1'b1);
    transact(1'b0, 4'h0, '0, '0, 2'b00, 3);
    transact(1'b0, 4'h8, '0, '0, 2'b00, 3);

    // randomized traffic
    rsp_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      cfg_aw_dly = $urandom_range(0, 3); cfg_w_dly = $urandom_range(0, 3);
      cfg_ar_dly = $urandom_range(0, 3); cfg_b_dly = $urandom_range(0, 3);
      cfg_r_dly  = $urandom_range(0, 3);
      d = $urandom;
      transact(1'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), 2'b00}, d,
               4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), -1);
    end
    rsp_rand = 1'b0;
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
